instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the control decoder. Takes instruction descriptions (kind + register/immediate fields)
//  over a valid/ready handshake and encodes each one into a 32-bit instruction word.
//  It writes the words one after another into instruction memory through a single write port.
//  Used to load programs into the single-cycle CPU's IMEM at bring-up and from the bench.
// PARAMETERS
//  ADDR_W     8  width of mem_addr (byte address)
//  BASE_ADDR  0  byte address of the first word written after start
//  MAX_WORDS 64  capacity in words; load ends when this many words are written
//  CNT_W      7  width of word_count; must hold MAX_WORDS
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous active-high reset
//  start        in   1       1-cycle pulse; begins a load session (used in IDLE/DONE only)
//  finish       in   1       1-cycle pulse; ends the session after any in-flight word
//  in_valid     in   1       instruction descriptor valid
//  in_ready     out  1       descriptor accepted when in_valid&in_ready
//  in_kind      in   3       0=R 1=LW 2=SW 3=ADDI 4=BEQ 5=SLTI 6,7=illegal
//  in_rs/rt/rd  in   5 each  register fields (rd used only for R)
//  in_funct     in   6       R-type funct
//  in_imm       in   16      I-type immediate; BEQ word offset, passed through unchanged
//  mem_we       out  1       IMEM write strobe
//  mem_addr     out  ADDR_W  IMEM byte address
//  mem_wdata    out  32      encoded instruction
//  word_count   out  CNT_W   words written this session
//  done         out  1       session over (level)
//  full         out  1       MAX_WORDS reached (level)
//  err_illegal  out  1       sticky: an illegal kind was offered this session
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0; mem_addr=BASE_ADDR; pending_finish=0.
//  Encoding opcodes: R=000000 LW=000100 SW=000101 ADDI=000111 BEQ=000110 SLTI=000001.
//   R word: {000000,rs,rt,rd,5'b0,funct}.
//   I word: {op,rs,rt,imm}.
//  FSM:
//   IDLE:   in_ready=0. On start: clear addr to BASE_ADDR, word_count, err_illegal,
//           done, full, pending_finish; go to ACCEPT.
//   ACCEPT: in_ready=1.
//           Legal transfer: latch the encoded word; go to WRITE.
//           Illegal transfer: set err_illegal and drop the descriptor; stay in ACCEPT.
//           finish with no transfer: done=1; go to DONE.
//           finish in the same cycle as a legal transfer: set pending_finish.
//   WRITE:  in_ready=0; mem_we=1 for exactly this cycle; mem_addr=current addr.
//           Next cycle: addr+=4 (wraps mod 2^ADDR_W); word_count+=1.
//           If word_count+1==MAX_WORDS: full=1, done=1, go to DONE.
//           Else if pending_finish or finish: done=1, go to DONE.
//           Else go to ACCEPT.
//   DONE:   in_ready=0; done and full hold their values.
//           start restarts the session exactly as from IDLE.
//  Timing and ignored inputs:
//   - Throughput is 1 word per 2 cycles; mem_we rises the cycle after acceptance.
//   - start is ignored in ACCEPT and WRITE; finish is ignored in IDLE and DONE.
//   - word_count and mem_addr are registered; mem_wdata is held while mem_we=1.
//   - rst during WRITE: mem_we drops immediately and the word is lost.
// TESTING
//  1. rst, start, ADDI rs=1 rt=2 imm=0x0005 -> next cycle: mem_we=1, addr=0x00, data=0x1C220005; word_count=1.
//  2. Then R rs=3 rt=4 rd=5 funct=0x20 -> addr=0x04, data=0x00642820.
//     Then LW rs=0 rt=8 imm=0xFFFC -> addr=0x08, data=0x1008FFFC.
//  3. SW rs=0 rt=8 imm=0xFFFC -> 0x1408FFFC; BEQ rs=1 rt=2 imm=0xFFFF -> 0x1822FFFF;
//     SLTI rs=2 rt=3 imm=0x000A -> 0x0443000A.
//  4. in_kind=6 with in_valid -> err_illegal=1, no mem_we, word_count unchanged, in_ready stays 1;
//     next start clears err_illegal.
//  5. MAX_WORDS=4: push 5 valid ADDIs -> 4 writes at 0x00..0x0C; then full=1, done=1, in_ready=0;
//     5th descriptor never accepted.
//  6. finish in the same cycle as a legal in_valid -> word written, then done=1, full=0.
//     Separately, rst asserted during WRITE -> mem_we=0 at once, state IDLE, word_count=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes instruction descriptors (kind + fields) into 32-bit words and streams
// them sequentially into instruction memory, one word per two cycles.
module instr_encoder_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          MAX_WORDS = 64,
    parameter int          CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  word_count,
    output logic              done,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WORDS);

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [31:0]       word_reg;
    logic              done_reg;
    logic              full_reg;
    logic              err_reg;
    logic              pend_reg;

    logic [5:0]        opcode;
    logic              enc_legal;
    logic [31:0]       enc_word;
    logic              accept;

    always_comb begin
        enc_legal = 1'b1;
        opcode    = 6'b000000;
        case (in_kind)
            3'd0:    opcode = 6'b000000;
            3'd1:    opcode = 6'b000100;
            3'd2:    opcode = 6'b000101;
            3'd3:    opcode = 6'b000111;
            3'd4:    opcode = 6'b000110;
            3'd5:    opcode = 6'b000001;
            default: enc_legal = 1'b0;
        endcase
        if (in_kind == 3'd0)
            enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
        else
            enc_word = {opcode, in_rs, in_rt, in_imm};
    end

    // mem_we is decoded from state so an async reset kills an in-flight write at once
    assign in_ready    = (state_reg == S_ACCEPT);
    assign mem_we      = (state_reg == S_WRITE);
    assign accept      = in_valid & in_ready;
    assign count_next  = count_reg + 1'b1;
    assign mem_addr    = addr_reg;
    assign mem_wdata   = word_reg;
    assign word_count  = count_reg;
    assign done        = done_reg;
    assign full        = full_reg;
    assign err_illegal = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= BASE;
            count_reg <= '0;
            word_reg  <= '0;
            done_reg  <= 1'b0;
            full_reg  <= 1'b0;
            err_reg   <= 1'b0;
            pend_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_reg  <= BASE;
                        count_reg <= '0;
                        done_reg  <= 1'b0;
                        full_reg  <= 1'b0;
                        err_reg   <= 1'b0;
                        pend_reg  <= 1'b0;
                        state_reg <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (accept && enc_legal) begin
                        word_reg  <= enc_word;
                        pend_reg  <= finish;
                        state_reg <= S_WRITE;
                    end else begin
                        // an illegal descriptor is consumed and dropped
                        if (accept)
                            err_reg <= 1'b1;
                        if (finish) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    addr_reg  <= addr_reg + ADDR_W'(4);
                    count_reg <= count_next;
                    if (count_next == CNT_LAST) begin
                        full_reg  <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (pend_reg || finish) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_ACCEPT;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed table, multi-cycle corner sequences
// and randomized sessions checked against a transaction-level model.
module tb_instr_encoder_loader;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm = '0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  word_count;
    logic        done;
    logic        full;
    logic        err_illegal;

    instr_encoder_loader #(
        .ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(MAXW), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .done(done),
        .full(full), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model of the current session
    int m_count;
    bit m_done;
    bit m_full;
    bit m_err;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int k, input int rs, input int rt,
                                             input int rd, input int fn, input int imm);
        int unsigned op;
        int unsigned w;
        case (k)
            1: op = 4;
            2: op = 5;
            3: op = 7;
            4: op = 6;
            5: op = 1;
            default: op = 0;
        endcase
        if (k == 0)
            w = rs * 2097152 + rt * 65536 + rd * 2048 + fn;
        else
            w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
        return w;
    endfunction

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_count = 0; m_done = 0; m_full = 0; m_err = 0;
        chk("start_ready", in_ready, 1);
        chk("start_count", word_count, 0);
        chk("start_done", done, 0);
        chk("start_full", full, 0);
        chk("start_err", err_illegal, 0);
        chk("start_addr", mem_addr, 0);
    endtask

    // fin_mode: 0 none, 1 finish alongside the descriptor, 2 finish during the write cycle
    task automatic push(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [31:0] exp_word, input int fin_mode);
        bit legal;
        legal = (k <= 3'd5);
        in_valid = 1'b1;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = fn; in_imm = imm;
        finish = (fin_mode == 1) && legal;
        tick();
        in_valid = 1'b0;
        finish = 1'b0;
        if (legal) begin
            chk("wr_we", mem_we, 1);
            chk("wr_ready", in_ready, 0);
            chk("wr_addr", mem_addr, (m_count * 4) % 256);
            chk("wr_data", mem_wdata, exp_word);
            finish = (fin_mode == 2);
            tick();
            finish = 1'b0;
            m_count++;
            if (m_count == MAXW) begin
                m_full = 1; m_done = 1;
            end else if (fin_mode != 0) begin
                m_done = 1;
            end
            chk("post_we", mem_we, 0);
            chk("post_count", word_count, m_count);
            chk("post_done", done, m_done);
            chk("post_full", full, m_full);
            chk("post_ready", in_ready, !m_done);
        end else begin
            m_err = 1;
            chk("ill_we", mem_we, 0);
            chk("ill_err", err_illegal, 1);
            chk("ill_ready", in_ready, 1);
            chk("ill_count", word_count, m_count);
        end
    endtask

    task automatic finish_idle();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        m_done = 1;
        chk("fin_done", done, 1);
        chk("fin_ready", in_ready, 0);
        chk("fin_full", full, m_full);
    endtask

    initial begin
        int writes;
        vecs[0] = '{3'd3, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 32'h1C220005};
        vecs[1] = '{3'd0, 5'd3, 5'd4, 5'd5, 6'h20, 16'h0000, 32'h00642820};
        vecs[2] = '{3'd1, 5'd0, 5'd8, 5'd0, 6'h00, 16'hFFFC, 32'h1008FFFC};
        vecs[3] = '{3'd2, 5'd0, 5'd8, 5'd0, 6'h00, 16'hFFFC, 32'h1408FFFC};
        vecs[4] = '{3'd4, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 32'h1822FFFF};
        vecs[5] = '{3'd5, 5'd2, 5'd3, 5'd0, 6'h00, 16'h000A, 32'h0443000A};

        // reset state
        tick();
        chk("rst_we", mem_we, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_count", word_count, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err_illegal, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", in_ready, 0);

        // directed encodings, two sessions of three words
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || i == 3)
                start_session();
            push(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].funct,
                 vecs[i].imm, vecs[i].word, 0);
            $display("vec %0d: addr=%h data=%h count=%0d", i, (m_count - 1) * 4, vecs[i].word, m_count);
            if (i == 2 || i == 5)
                finish_idle();
        end

        // illegal kinds, finish ignored in DONE, start clears error
        start_session();
        push(3'd6, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 32'h0, 0);
        push(3'd7, 5'd2, 5'd2, 5'd2, 6'h2, 16'h2, 32'h0, 0);
        finish_idle();
        finish_idle();
        chk("done_hold_count", word_count, 0);
        chk("done_hold_err", err_illegal, 1);
        start_session();

        // capacity: hold five ADDIs valid, only four are written
        in_valid = 1'b1;
        in_kind = 3'd3; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h0005;
        writes = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (mem_we) begin
                chk("cap_addr", mem_addr, writes * 4);
                chk("cap_data", mem_wdata, 32'h1C220005);
                writes++;
            end
        end
        in_valid = 1'b0;
        chk("cap_writes", writes, 4);
        chk("cap_full", full, 1);
        chk("cap_done", done, 1);
        chk("cap_ready", in_ready, 0);
        chk("cap_count", word_count, 4);
        $display("capacity: writes=%0d full=%0b done=%0b", writes, full, done);

        // finish together with a legal descriptor
        start_session();
        push(3'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0005, 32'h1C220005, 1);
        chk("pend_done", done, 1);
        chk("pend_full", full, 0);

        // reset during the write cycle
        start_session();
        in_valid = 1'b1;
        in_kind = 3'd3;
        tick();
        in_valid = 1'b0;
        chk("rw_we_before", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rw_we", mem_we, 0);
        chk("rw_ready", in_ready, 0);
        tick();
        chk("rw_count", word_count, 0);
        chk("rw_addr", mem_addr, 0);
        rst = 1'b0;
        tick();
        chk("rw_idle", in_ready, 0);
        $display("reset-in-write: we=%0b count=%0d", mem_we, word_count);

        // randomized sessions
        for (int s = 0; s < 25; s++) begin
            int ops;
            start_session();
            ops = $urandom_range(1, 6);
            for (int o = 0; o < ops && !m_done; o++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    push(3'(6 + $urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                         5'($urandom), 6'($urandom), 16'($urandom), 32'h0, 0);
                end else if (r == 1) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    chk("rnd_start_ign_ready", in_ready, 1);
                    chk("rnd_start_ign_count", word_count, m_count);
                    chk("rnd_start_ign_err", err_illegal, m_err);
                end else begin
                    logic [2:0]  k;
                    logic [4:0]  rs, rt, rd;
                    logic [5:0]  fn;
                    logic [15:0] imm;
                    k = 3'($urandom_range(0, 5));
                    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
                    fn = 6'($urandom); imm = 16'($urandom);
                    push(k, rs, rt, rd, fn, imm, ref_word(k, rs, rt, rd, fn, imm),
                         (r == 8) ? 1 : (r == 9) ? 2 : 0);
                end
            end
            if (!m_done)
                finish_idle();
            chk("rnd_end_done", done, 1);
            chk("rnd_end_full", full, m_full);
            chk("rnd_end_err", err_illegal, m_err);
            chk("rnd_end_count", word_count, m_count);
            $display("session %0d: words=%0d full=%0b err=%0b", s, m_count, m_full, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
